cache_backing_ram: RTL and testbench
====================================

Name: cache_backing_ram

Overview:
- Main-memory responder on the far side of the cache fill/write-through interface.
- Accepts a single-word read or write request from the cache controller when `enable` is pulsed.
- Models access delay with a latency counter.
- Returns read data on `q` with a one-cycle `valid` strobe.
- Sits directly below the 4-way cache and replaces the zero-latency RAM stub used until now.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- READ_LAT, 4, cycles from request acceptance to read-data `valid`; at least 1.
- WRITE_LAT, 2, cycles from request acceptance to write commit and `valid`; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  request strobe; sampled only when `ready`=1.
- wr  in  1  1 = write request, 0 = read request; sampled with `enable`.
- addr  in  32  byte address; word index = addr[log2(DEPTH)+1:2]; bits [1:0] and upper bits ignored (aliasing).
- data  in  32  write data; sampled with `enable`.
- q  out  32  read data; holds the last completed read.
- ready  out  1  responder idle, can accept a request.
- valid  out  1  one-cycle strobe: request completed (read data on `q` or write committed).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, ready=1, valid=0, q=0, counter=0.
  - Memory array is not cleared.
  - Reset dominates `enable` in the same cycle.
- States:
  - IDLE (ready=1, valid=0).
  - BUSY (ready=0, valid=0).
  - DONE (ready=0, valid=1).
- IDLE with enable=1:
  - Latch addr, data, wr.
  - Counter = (wr ? WRITE_LAT : READ_LAT) - 1.
  - Go to BUSY.
- IDLE with enable=0: stay in IDLE.
- BUSY, counter≠0: decrement the counter.
- BUSY, counter=0:
  - Read: q <= mem[latched index].
  - Write: mem[latched index] <= latched data; q unchanged.
  - Go to DONE.
- DONE: go to IDLE unconditionally.
- Timing: request accepted at edge E0.
  - `valid` is high in the cycle after edge E0+LAT.
  - `ready` returns after edge E0+LAT+1.
  - Next request can be accepted at edge E0+LAT+2.
  - Throughput: one request per LAT+2 cycles.
- `enable` while ready=0 (BUSY or DONE) is ignored: no queueing, no error.
- addr/data/wr changes after acceptance have no effect on the in-flight request.
- Read of a never-written word returns the simulation initial contents (X); benches must write before reading.
- Read-after-write to the same index: the second request sees the new data, because the write commits before `ready` returns.
- Reset mid-operation: the in-flight request is abandoned.
  - A pending write is NOT committed.
  - A pending read does not update `q`.
- The cache controller must hold `enable` for exactly one accepted cycle and wait for `valid`; a fixed-delay wait is not a legal use of this block.

Optional Feature:
- Macro: CACHE_BACKING_RAM_STATS_EN.
- Defined:
  - Adds outputs `rd_count` (out, 16) and `wr_count` (out, 16), reset to 0.
  - Each increments by 1 on the edge entering DONE for a completed read / write respectively.
  - Both wrap from 0xFFFF to 0x0000.
  - Abandoned (reset) requests are not counted.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → ready=1, valid=0, q=0x00000000; counters 0 if stats enabled.
- Write then read (defaults):
  - Write addr=0x10, data=0xDEADBEEF → valid pulses 1 cycle, 2 cycles after acceptance edge; q stays 0.
  - Read addr=0x10 → valid 4 cycles after acceptance, q=0xDEADBEEF and held afterwards.
- Aliasing and low bits:
  - Write addr=0x404, data=0x12345678; read addr=0x007 → q=0x12345678 (index 1, DEPTH=256).
- Busy rejection:
  - Read addr=0x10, then enable=1 with wr=1, data=0x0 on every cycle while ready=0 → mem[4] unchanged.
  - Read returns 0xDEADBEEF; only one valid pulse per accepted request.
- Reset mid-write:
  - Write addr=0x20, data=0xCAFEF00D; assert rst one cycle after acceptance.
  - Then read addr=0x20 → old contents, not 0xCAFEF00D; wr_count=0 when stats enabled.
- Stats wrap (with CACHE_BACKING_RAM_STATS_EN): force rd_count to 0xFFFF, complete one read → rd_count=0x0000.

Source files
------------

// File: rtl/cache_backing_ram.sv
// Main-memory responder below the cache: one read or write per request, with configurable latency.
// Optional request statistics (rd_count / wr_count) are built when CACHE_BACKING_RAM_STATS_EN is defined.
module cache_backing_ram #(
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [31:0] q,
    output logic        ready,
    output logic        valid
`ifdef CACHE_BACKING_RAM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int AW      = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_RD   = CW'(READ_LAT - 1);
    localparam logic [CW-1:0] CNT_WR   = CW'(WRITE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    logic            ready_r, ready_nx_s;
    logic            valid_r, valid_nx_s;
    logic            accept_s, commit_s;
    logic [AW-1:0]   idx_r;
    logic [31:0]     data_r;
    logic            wr_r;
    logic [31:0]     q_r;
    logic [31:0]     mem_r [0:DEPTH-1];
    logic            addr_unused_s;

    // Byte-lane and aliased upper address bits do not select a word.
    assign addr_unused_s = ^{addr[31:AW+2], addr[1:0]};

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    accept_s   = 1'b1;
                    state_nx_s = BUSY;
                    cnt_nx_s   = wr ? CNT_WR : CNT_RD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    commit_s   = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
        ready_nx_s = (state_nx_s == IDLE);
        valid_nx_s = (state_nx_s == DONE);
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            ready_r <= ready_nx_s;
            valid_r <= valid_nx_s;
        end
    end

    // Request capture and read-data register; a reset abandons any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r  <= {AW{1'b0}};
            data_r <= 32'h0000_0000;
            wr_r   <= 1'b0;
            q_r    <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                idx_r  <= addr[AW+1:2];
                data_r <= data;
                wr_r   <= wr;
            end
            if (commit_s && !wr_r) begin
                q_r <= mem_r[idx_r];
            end
        end
    end

    // Storage array is never cleared; a write pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit_s && wr_r) begin
            mem_r[idx_r] <= data_r;
        end
    end

    assign q     = q_r;
    assign ready = ready_r;
    assign valid = valid_r;

`ifdef CACHE_BACKING_RAM_STATS_EN
    logic [15:0] rd_count_r, wr_count_r;

    // Completed-request counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_r <= 16'h0000;
            wr_count_r <= 16'h0000;
        end else if (commit_s) begin
            if (wr_r) begin
                wr_count_r <= wr_count_r + 16'h0001;
            end else begin
                rd_count_r <= rd_count_r + 16'h0001;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_cache_backing_ram.sv
// Randomized and directed checks of cache_backing_ram against an array-based memory model.
module tb_cache_backing_ram;

    localparam int DEPTH     = 256;
    localparam int READ_LAT  = 4;
    localparam int WRITE_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] q;
    logic        ready;
    logic        valid;
`ifdef CACHE_BACKING_RAM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem_m [int];
    logic [31:0] q_m;
    int          rd_m;
    int          wr_m;
    int          widx [$];

    always #5 clk = ~clk;

    cache_backing_ram #(
        .DEPTH(DEPTH),
        .READ_LAT(READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .wr(wr),
        .addr(addr),
        .data(data),
        .q(q),
        .ready(ready),
        .valid(valid)
`ifdef CACHE_BACKING_RAM_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_stats();
`ifdef CACHE_BACKING_RAM_STATS_EN
        check("rd_count", {16'h0000, rd_count}, rd_m[15:0]);
        check("wr_count", {16'h0000, wr_count}, wr_m[15:0]);
`endif
    endtask

    // One request, with cycle-by-cycle checks of valid/ready/q; optional junk on inputs while busy.
    task automatic request(input logic w, input logic [31:0] a, input logic [31:0] d, input bit spam);
        int          lat;
        int          idx;
        int          waited;
        logic [31:0] q_before;
        waited = 0;
        while (ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_req", {31'd0, ready}, 32'd1);
        enable = 1'b1;
        wr     = w;
        addr   = a;
        data   = d;
        @(posedge clk);
        lat      = w ? WRITE_LAT : READ_LAT;
        idx      = int'((a >> 2) % DEPTH);
        q_before = q_m;
        if (w) begin
            mem_m[idx] = d;
            wr_m++;
        end else begin
            q_m = mem_m[idx];
            rd_m++;
        end
        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clk);
            check($sformatf("valid_k%0d", k), {31'd0, valid}, {31'd0, (k == lat)});
            check($sformatf("ready_k%0d", k), {31'd0, ready}, {31'd0, (k == lat + 1)});
            check($sformatf("q_k%0d", k), q, (k >= lat && !w) ? q_m : q_before);
            if (spam && k <= lat) begin
                enable = 1'b1;
                wr     = 1'b1;
                data   = 32'h0000_0000;
                addr   = $urandom;
            end else begin
                enable = 1'b0;
            end
        end
        check_stats();
    endtask

    initial begin
        int          idx;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;

        rst    = 1'b1;
        enable = 1'b0;
        wr     = 1'b0;
        addr   = 32'h0000_0000;
        data   = 32'h0000_0000;
        q_m    = 32'h0000_0000;
        rd_m   = 0;
        wr_m   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_q", q, 32'h0000_0000);
        check_stats();

        request(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        request(1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0);
        request(1'b1, 32'h0000_0404, 32'h1234_5678, 1'b0);
        request(1'b0, 32'h0000_0007, 32'h0000_0000, 1'b0);
        request(1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1);
        request(1'b0, 32'h0000_0013, 32'h0000_0000, 1'b0);
        widx.push_back(4);
        widx.push_back(1);

        request(1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0);
        widx.push_back(8);
        enable = 1'b1;
        wr     = 1'b1;
        addr   = 32'h0000_0020;
        data   = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q_m  = 32'h0000_0000;
        rd_m = 0;
        wr_m = 0;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_q", q, 32'h0000_0000);
        check_stats();
        @(negedge clk);
        check("midrst_valid_later", {31'd0, valid}, 32'd0);
        request(1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0);

        for (int n = 0; n < 24; n++) begin
            w = ($urandom_range(0, 1) == 1);
            if (w) begin
                idx = $urandom_range(0, DEPTH - 1);
                widx.push_back(idx);
                d = $urandom;
            end else begin
                idx = widx[$urandom_range(0, widx.size() - 1)];
                d = $urandom;
            end
            a = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            request(w, a, d, ($urandom_range(0, 3) == 0));
        end

`ifdef CACHE_BACKING_RAM_STATS_EN
        @(negedge clk);
        force dut.rd_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.rd_count_r;
        rd_m = 32'h0000_FFFF;
        request(1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
